// File: rtl/eth_tx_arb.sv
// eth_tx_arb: N-to-1 Ethernet frame arbiter feeding eth_axis_tx.
// One source owns the downstream interface from header acceptance until its
// payload tlast beat. Header and payload paths are combinational pass-throughs
// of the granted source; arbitration costs one IDLE cycle per frame.
// Build option: define ETH_TX_ARB_PRIO_EN for fixed priority (lowest index
// wins); default build is round-robin with fairness over whole frames.

module eth_tx_arb #(
  parameter int unsigned S_COUNT    = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [S_COUNT-1:0]            s_eth_hdr_valid,
  output logic [S_COUNT-1:0]            s_eth_hdr_ready,
  input  logic [S_COUNT*48-1:0]         s_eth_dest_mac,
  input  logic [S_COUNT*48-1:0]         s_eth_src_mac,
  input  logic [S_COUNT*16-1:0]         s_eth_type,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [S_COUNT-1:0]            s_eth_payload_axis_tvalid,
  output logic [S_COUNT-1:0]            s_eth_payload_axis_tready,
  input  logic [S_COUNT-1:0]            s_eth_payload_axis_tlast,
  input  logic [S_COUNT-1:0]            s_eth_payload_axis_tuser,

  output logic                          m_eth_hdr_valid,
  input  logic                          m_eth_hdr_ready,
  output logic [47:0]                   m_eth_dest_mac,
  output logic [47:0]                   m_eth_src_mac,
  output logic [15:0]                   m_eth_type,
  output logic [DATA_WIDTH-1:0]         m_eth_payload_axis_tdata,
  output logic                          m_eth_payload_axis_tvalid,
  input  logic                          m_eth_payload_axis_tready,
  output logic                          m_eth_payload_axis_tlast,
  output logic                          m_eth_payload_axis_tuser,

  output logic [S_COUNT-1:0]            grant,
  output logic                          busy
);

  localparam int unsigned SEL_WIDTH = $clog2(S_COUNT);
  localparam int unsigned MAC_W     = 48;
  localparam int unsigned TYPE_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [S_COUNT-1:0]     grant_q, grant_d;
  logic [SEL_WIDTH-1:0]   grant_idx_q, grant_idx_d;

  logic                   win_valid_c;
  logic [SEL_WIDTH-1:0]   win_idx_c;

  // Per-source views of the packed input buses
  logic [MAC_W-1:0]       dest_mac_a [S_COUNT];
  logic [MAC_W-1:0]       src_mac_a  [S_COUNT];
  logic [TYPE_W-1:0]      type_a     [S_COUNT];
  logic [DATA_WIDTH-1:0]  tdata_a    [S_COUNT];

  for (genvar i = 0; i < int'(S_COUNT); i++) begin : g_unpack
    assign dest_mac_a[i] = s_eth_dest_mac[i*MAC_W +: MAC_W];
    assign src_mac_a[i]  = s_eth_src_mac[i*MAC_W +: MAC_W];
    assign type_a[i]     = s_eth_type[i*TYPE_W +: TYPE_W];
    assign tdata_a[i]    = s_eth_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef ETH_TX_ARB_PRIO_EN
  // Fixed priority: lowest requesting index wins
  always_comb begin
    win_valid_c = |s_eth_hdr_valid;
    win_idx_c   = '0;
    for (int i = int'(S_COUNT) - 1; i >= 0; i--) begin
      if (s_eth_hdr_valid[SEL_WIDTH'(i)]) begin
        win_idx_c = SEL_WIDTH'(i);
      end
    end
  end
`else
  logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

  // Round-robin: first requester at or after rr_ptr, wrapping
  always_comb begin : rr_search
    logic        found;
    int unsigned idx;
    win_valid_c = |s_eth_hdr_valid;
    win_idx_c   = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < S_COUNT; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= S_COUNT) begin
        idx = idx - S_COUNT;
      end
      if (!found && s_eth_hdr_valid[SEL_WIDTH'(idx)]) begin
        found     = 1'b1;
        win_idx_c = SEL_WIDTH'(idx);
      end
    end
  end

  // Pointer moves past the owner only when its frame completes
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_PAYLOAD &&
        s_eth_payload_axis_tvalid[grant_idx_q] &&
        m_eth_payload_axis_tready &&
        s_eth_payload_axis_tlast[grant_idx_q]) begin
      if (32'(grant_idx_q) == S_COUNT - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_q + SEL_WIDTH'(1);
      end
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Next-state, grant update and pass-through muxing of the granted source
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;

    s_eth_hdr_ready           = '0;
    s_eth_payload_axis_tready = '0;
    m_eth_hdr_valid           = 1'b0;
    m_eth_payload_axis_tvalid = 1'b0;
    m_eth_payload_axis_tlast  = 1'b0;
    m_eth_payload_axis_tuser  = 1'b0;
    m_eth_dest_mac            = dest_mac_a[grant_idx_q];
    m_eth_src_mac             = src_mac_a[grant_idx_q];
    m_eth_type                = type_a[grant_idx_q];
    m_eth_payload_axis_tdata  = tdata_a[grant_idx_q];

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid_c) begin
          state_d     = ST_HDR;
          grant_idx_d = win_idx_c;
          grant_d     = S_COUNT'(1) << win_idx_c;
        end
      end

      ST_HDR: begin
        m_eth_hdr_valid                = s_eth_hdr_valid[grant_idx_q];
        s_eth_hdr_ready[grant_idx_q]   = m_eth_hdr_ready;
        if (!s_eth_hdr_valid[grant_idx_q]) begin
          // Source withdrew its header: release without advancing fairness
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (m_eth_hdr_ready) begin
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        m_eth_payload_axis_tvalid                = s_eth_payload_axis_tvalid[grant_idx_q];
        m_eth_payload_axis_tlast                 = s_eth_payload_axis_tlast[grant_idx_q];
        m_eth_payload_axis_tuser                 = s_eth_payload_axis_tuser[grant_idx_q];
        s_eth_payload_axis_tready[grant_idx_q]   = m_eth_payload_axis_tready;
        if (s_eth_payload_axis_tvalid[grant_idx_q] && m_eth_payload_axis_tready &&
            s_eth_payload_axis_tlast[grant_idx_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and owner index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb (4 sources, byte payload): directed vector table,
// hand sequences for multi-cycle corners, then randomized traffic checked
// every cycle against a frame-level ownership model.

module tb_eth_tx_arb;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [S-1:0]      hv, hr, tv, tr, tl, tu;
  logic [47:0]       dmac_a [S];
  logic [47:0]       smac_a [S];
  logic [15:0]       type_a [S];
  logic [DW-1:0]     td_a   [S];
  logic [S*48-1:0]   dmac, smac;
  logic [S*16-1:0]   etype;
  logic [S*DW-1:0]   td;
  logic              mhv, mhr, mtv, mtr, mtl, mtu;
  logic [47:0]       mdmac, msmac;
  logic [15:0]       mtype;
  logic [DW-1:0]     mtd;
  logic [S-1:0]      grant;
  logic              busy;

  always_comb begin
    for (int i = 0; i < S; i++) begin
      dmac[i*48 +: 48]  = dmac_a[i];
      smac[i*48 +: 48]  = smac_a[i];
      etype[i*16 +: 16] = type_a[i];
      td[i*DW +: DW]    = td_a[i];
    end
  end

  eth_tx_arb #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_eth_hdr_valid           (hv),
    .s_eth_hdr_ready           (hr),
    .s_eth_dest_mac            (dmac),
    .s_eth_src_mac             (smac),
    .s_eth_type                (etype),
    .s_eth_payload_axis_tdata  (td),
    .s_eth_payload_axis_tvalid (tv),
    .s_eth_payload_axis_tready (tr),
    .s_eth_payload_axis_tlast  (tl),
    .s_eth_payload_axis_tuser  (tu),
    .m_eth_hdr_valid           (mhv),
    .m_eth_hdr_ready           (mhr),
    .m_eth_dest_mac            (mdmac),
    .m_eth_src_mac             (msmac),
    .m_eth_type                (mtype),
    .m_eth_payload_axis_tdata  (mtd),
    .m_eth_payload_axis_tvalid (mtv),
    .m_eth_payload_axis_tready (mtr),
    .m_eth_payload_axis_tlast  (mtl),
    .m_eth_payload_axis_tuser  (mtu),
    .grant                     (grant),
    .busy                      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: who owns the output (-1 = nobody), whether the owner
  // is still presenting its header, and the next round-robin starting index.
  int m_owner = -1;
  bit m_hdr   = 1'b0;
  int m_rr    = 0;

  function automatic int pick(input logic [S-1:0] v, input int start);
    for (int k = 0; k < S; k++) begin
`ifdef ETH_TX_ARB_PRIO_EN
      if (v[SW'(k)]) return k;
`else
      if (v[SW'((start + k) % S)]) return (start + k) % S;
`endif
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hdr   = 1'b0;
    m_rr    = 0;
  endtask

  task automatic check_model();
    logic [S-1:0] eg, ehr, etr;
    logic         ehv, etv;
    eg = '0; ehr = '0; etr = '0;
    ehv = 1'b0; etv = 1'b0;
    if (m_owner >= 0) begin
      eg[SW'(m_owner)] = 1'b1;
      if (m_hdr) begin
        ehv = hv[SW'(m_owner)];
        if (mhr) ehr[SW'(m_owner)] = 1'b1;
      end else begin
        etv = tv[SW'(m_owner)];
        if (mtr) etr[SW'(m_owner)] = 1'b1;
      end
    end
    cmp("grant", 64'(grant), 64'(eg));
    cmp("busy", 64'(busy), 64'(m_owner >= 0));
    cmp("m_hdr_valid", 64'(mhv), 64'(ehv));
    cmp("s_hdr_ready", 64'(hr), 64'(ehr));
    cmp("m_tvalid", 64'(mtv), 64'(etv));
    cmp("s_tready", 64'(tr), 64'(etr));
    if (ehv) begin
      cmp("m_dest_mac", 64'(mdmac), 64'(dmac_a[SW'(m_owner)]));
      cmp("m_src_mac", 64'(msmac), 64'(smac_a[SW'(m_owner)]));
      cmp("m_type", 64'(mtype), 64'(type_a[SW'(m_owner)]));
    end
    if (etv) begin
      cmp("m_tdata", 64'(mtd), 64'(td_a[SW'(m_owner)]));
      cmp("m_tlast", 64'(mtl), 64'(tl[SW'(m_owner)]));
      cmp("m_tuser", 64'(mtu), 64'(tu[SW'(m_owner)]));
    end
  endtask

  task automatic model_next();
    if (m_owner < 0) begin
      if (|hv) begin
        m_owner = pick(hv, m_rr);
        m_hdr   = 1'b1;
      end
    end else if (m_hdr) begin
      if (!hv[SW'(m_owner)]) m_owner = -1;
      else if (mhr) m_hdr = 1'b0;
    end else if (tv[SW'(m_owner)] && mtr && tl[SW'(m_owner)]) begin
      m_rr    = (m_owner + 1) % S;
      m_owner = -1;
    end
  endtask

  // Called at the falling edge after any extra checks; ends at posedge+1
  task automatic finish_cycle();
    check_model();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic idle_inputs();
    hv = '0; tv = '0; tl = '0; tu = '0;
    mhr = 1'b0; mtr = 1'b0;
    for (int i = 0; i < S; i++) begin
      dmac_a[i] = 48'h0A0000000000 + 48'(i);
      smac_a[i] = 48'h0B0000000000 + 48'(i);
      type_a[i] = 16'h0800 + 16'(i);
      td_a[i]   = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Lone request from src, header accepted at once, nbeats back-to-back
  task automatic run_frame(input int src, input int nbeats);
    idle_inputs();
    hv[SW'(src)] = 1'b1;
    mhr = 1'b1;
    tick();
    tick();
    hv = '0;
    mtr = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      tv[SW'(src)]   = 1'b1;
      tl[SW'(src)]   = (b == nbeats - 1);
      td_a[SW'(src)] = DW'($urandom());
      tick();
    end
    idle_inputs();
    tick();
  endtask

  typedef struct {
    logic [S-1:0] hv, tv, tl;
    logic         mhr, mtr;
    logic [7:0]   d;
    logic [S-1:0] eg;
    logic         eb, ehv, etv;
    logic [S-1:0] ehr, etr;
    logic [7:0]   ed;
    logic         el;
  } vec_t;

  vec_t vecs [6];
  int   order [$];
  logic [S-1:0] prev_grant;
  logic [S-1:0] beat_cnt;
  int   exp_order;

  initial begin
    // Single source 1: header then AA, BB, CC(last)
    vecs[0] = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h00,
                4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0};
    vecs[1] = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h00,
                4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b0000, 8'h00, 1'b0};
    vecs[2] = '{4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'hAA,
                4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 8'hAA, 1'b0};
    vecs[3] = '{4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'hBB,
                4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 8'hBB, 1'b0};
    vecs[4] = '{4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1, 8'hCC,
                4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 8'hCC, 1'b1};
    vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h00,
                4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0};

    rst = 1'b1;
    idle_inputs();
    #1;
    cmp("rst_grant", 64'(grant), 64'(0));
    cmp("rst_busy", 64'(busy), 64'(0));
    cmp("rst_hdr_valid", 64'(mhv), 64'(0));
    cmp("rst_tvalid", 64'(mtv), 64'(0));
    cmp("rst_hdr_ready", 64'(hr), 64'(0));
    cmp("rst_tready", 64'(tr), 64'(0));
    do_reset();

    // Directed table
    for (int v = 0; v < 6; v++) begin
      idle_inputs();
      hv = vecs[v].hv; tv = vecs[v].tv; tl = vecs[v].tl;
      mhr = vecs[v].mhr; mtr = vecs[v].mtr;
      td_a[1] = vecs[v].d;
      @(negedge clk);
      cmp("tbl_grant", 64'(grant), 64'(vecs[v].eg));
      cmp("tbl_busy", 64'(busy), 64'(vecs[v].eb));
      cmp("tbl_hdr_valid", 64'(mhv), 64'(vecs[v].ehv));
      cmp("tbl_tvalid", 64'(mtv), 64'(vecs[v].etv));
      cmp("tbl_hdr_ready", 64'(hr), 64'(vecs[v].ehr));
      cmp("tbl_tready", 64'(tr), 64'(vecs[v].etr));
      if (vecs[v].etv) begin
        cmp("tbl_tdata", 64'(mtd), 64'(vecs[v].ed));
        cmp("tbl_tlast", 64'(mtl), 64'(vecs[v].el));
      end
      finish_cycle();
    end

    // All sources requesting continuously with 2-beat frames
    do_reset();
    hv = '1; tv = '1; mhr = 1'b1; mtr = 1'b1;
    beat_cnt = '0;
    prev_grant = '0;
    for (int c = 0; c < 21; c++) begin
      tl = beat_cnt;
      @(negedge clk);
      if (grant != '0 && prev_grant == '0) begin
        for (int i = 0; i < S; i++) if (grant[SW'(i)]) order.push_back(i);
      end
      prev_grant = grant;
      beat_cnt = beat_cnt ^ (tr & tv);
      finish_cycle();
    end
    for (int f = 0; f < 5; f++) begin
`ifdef ETH_TX_ARB_PRIO_EN
      exp_order = 0;
`else
      exp_order = f % S;
`endif
      cmp("grant_order", 64'((f < order.size()) ? order[f] : -1), 64'(exp_order));
    end

    // Header withdrawn before acceptance keeps the round-robin pointer
    do_reset();
    run_frame(0, 1);
    idle_inputs();
    hv = 4'b0100;
    tick();
    tick();
    hv = '0;
    @(negedge clk);
    cmp("drop_grant_held", 64'(grant), 64'(4'b0100));
    cmp("drop_hdr_valid", 64'(mhv), 64'(0));
    finish_cycle();
    hv = 4'b1010;
    tick();
    @(negedge clk);
    cmp("after_drop_grant", 64'(grant), 64'(4'b0010));
    finish_cycle();

    // Reset mid-payload clears everything and restarts fairness at 0
    do_reset();
    run_frame(1, 1);
    idle_inputs();
    hv = 4'b1000; mhr = 1'b1;
    tick();
    tick();
    hv = '0; tv = 4'b1000; mtr = 1'b1;
    tick();
    #1;
    cmp("pre_rst_tready", 64'(tr), 64'(4'b1000));
    rst = 1'b1;
    #1;
    cmp("mid_rst_grant", 64'(grant), 64'(0));
    cmp("mid_rst_busy", 64'(busy), 64'(0));
    cmp("mid_rst_tvalid", 64'(mtv), 64'(0));
    cmp("mid_rst_tready", 64'(tr), 64'(0));
    cmp("mid_rst_hdr_valid", 64'(mhv), 64'(0));
    cmp("mid_rst_hdr_ready", 64'(hr), 64'(0));
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    hv = 4'b0101;
    tick();
    @(negedge clk);
    cmp("post_rst_grant", 64'(grant), 64'(4'b0001));
    finish_cycle();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < S; i++) begin
        hv[SW'(i)] = ($urandom_range(0, 99) < 50);
        tv[SW'(i)] = ($urandom_range(0, 99) < 70);
        tl[SW'(i)] = ($urandom_range(0, 99) < 25);
        tu[SW'(i)] = 1'($urandom());
        dmac_a[i]  = 48'({$urandom(), $urandom()});
        smac_a[i]  = 48'({$urandom(), $urandom()});
        type_a[i]  = 16'($urandom());
        td_a[i]    = DW'($urandom());
      end
      mhr = ($urandom_range(0, 99) < 60);
      mtr = ($urandom_range(0, 99) < 60);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
